// File: rtl/rc4_key_dispatcher_if.sv
// ---------------------------------------------------------------------------
// rc4_key_dispatcher_if
//
// Purpose: bundles the per-core launch/result handshake between the RC4 key
// dispatcher and its array of load/shuffle/decrypt cores.
//
// Signals:
//   core_start  [NUM_CORES]        one-cycle launch pulse per core
//   core_key    [NUM_CORES*KEY_W]  slice i = key held for core i
//   core_abort                     one-cycle pulse; all cores drop their work
//   core_done   [NUM_CORES]        one-cycle completion pulse per core
//   core_valid  [NUM_CORES]        qualifies core_done: plaintext passed check
//
// Modports:
//   master  dispatcher side (drives start/key/abort, receives done/valid)
//   slave   core-array side
// ---------------------------------------------------------------------------
interface rc4_key_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);

  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic                       core_abort;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_valid;

  modport master (
    output core_start,
    output core_key,
    output core_abort,
    input  core_done,
    input  core_valid
  );

  modport slave (
    input  core_start,
    input  core_key,
    input  core_abort,
    output core_done,
    output core_valid
  );

endinterface

// File: rtl/rc4_key_dispatcher.sv
// ---------------------------------------------------------------------------
// rc4_key_dispatcher
//
// Purpose: dynamic key-search controller for the RC4 cracker. Hands the next
// untried key to the lowest-index idle core (one dispatch per cycle), counts
// completed decrypts, and stops on the first valid decryption (FOUND, with a
// single abort pulse to the cores) or when the key range START_KEY..MAX_KEY
// has been dispatched and every core has drained (EXHAUSTED).
//
// Ports:
//   clk          in   single clock for the block and all cores
//   reset        in   synchronous active-high reset, back to IDLE
//   start        in   level; begins a new search in IDLE/FOUND/EXHAUSTED
//   pause        in   level; suppresses new dispatches, results still counted
//   cores        if   master side of rc4_key_dispatcher_if (its NUM_CORES and
//                     KEY_W must match this module's parameters)
//   busy         out  high in RUN
//   found        out  high in FOUND
//   exhausted    out  high in EXHAUSTED
//   found_key    out  winning key, held in FOUND
//   found_core   out  index of the winning core
//   display_key  out  most recently dispatched key
//   keys_tried   out  completed decrypts in the current search
// ---------------------------------------------------------------------------
module rc4_key_dispatcher #(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] START_KEY = {KEY_W{1'b0}},
  parameter logic [KEY_W-1:0] MAX_KEY   = KEY_W'(24'h3FFFFF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  rc4_key_dispatcher_if.master cores,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_W-1:0]     found_key,
  output logic [3:0]           found_core,
  output logic [KEY_W-1:0]     display_key,
  output logic [KEY_W:0]       keys_tried
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_FOUND     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } state_t;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [3:0] first_set(input logic [NUM_CORES-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Number of set bits, sized to add straight into keys_tried.
  function automatic logic [KEY_W:0] pop_count(input logic [NUM_CORES-1:0] vec);
    logic [KEY_W:0] cnt;
    cnt = {(KEY_W+1){1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt = cnt + (KEY_W+1)'(vec[i]);
    end
    return cnt;
  endfunction

  state_t                     state_r;
  logic [NUM_CORES-1:0]       core_busy_r;
  logic [NUM_CORES-1:0]       core_start_r;
  logic [NUM_CORES*KEY_W-1:0] core_key_r;
  logic                       core_abort_r;
  // One bit wider than a key so MAX_KEY = 2^KEY_W-1 ends the range instead
  // of wrapping back to zero.
  logic [KEY_W:0]             next_key_r;

  logic [NUM_CORES-1:0]       done_s;
  logic [NUM_CORES-1:0]       hit_s;
  logic [NUM_CORES-1:0]       free_s;
  logic [NUM_CORES-1:0]       disp_mask_s;
  logic                       hit_any_s;
  logic [3:0]                 hit_idx_s;
  logic [KEY_W-1:0]           hit_key_s;
  logic [3:0]                 disp_idx_s;
  logic                       keys_left_s;
  logic                       can_disp_s;
  logic                       all_free_s;
  logic [KEY_W:0]             done_cnt_s;

  assign cores.core_start = core_start_r;
  assign cores.core_key   = core_key_r;
  assign cores.core_abort = core_abort_r;

  // Result decode and dispatch selection for the current cycle.
  always_comb begin
    // A done from a core we never launched is a protocol error: drop it.
    done_s      = cores.core_done & core_busy_r;
    hit_s       = done_s & cores.core_valid;
    // A core finishing this cycle is already free for the next dispatch.
    free_s      = ~core_busy_r | done_s;
    hit_any_s   = |hit_s;
    hit_idx_s   = first_set(hit_s);
    hit_key_s   = core_key_r[int'(hit_idx_s) * KEY_W +: KEY_W];
    disp_idx_s  = first_set(free_s);
    disp_mask_s = NUM_CORES'(1'b1) << disp_idx_s;
    keys_left_s = (next_key_r <= {1'b0, MAX_KEY});
    all_free_s  = &free_s;
    done_cnt_s  = pop_count(done_s);
    if (keys_left_s && !pause && !hit_any_s && (|free_s)) begin
      can_disp_s = 1'b1;
    end else begin
      can_disp_s = 1'b0;
    end
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Cores share this reset, so no abort pulse is needed here.
      state_r      <= ST_IDLE;
      core_busy_r  <= {NUM_CORES{1'b0}};
      core_start_r <= {NUM_CORES{1'b0}};
      core_key_r   <= {(NUM_CORES*KEY_W){1'b0}};
      core_abort_r <= 1'b0;
      next_key_r   <= {(KEY_W+1){1'b0}};
      busy         <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      found_key    <= {KEY_W{1'b0}};
      found_core   <= 4'd0;
      display_key  <= {KEY_W{1'b0}};
      keys_tried   <= {(KEY_W+1){1'b0}};
    end else begin
      core_start_r <= {NUM_CORES{1'b0}};
      core_abort_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            state_r     <= ST_RUN;
            next_key_r  <= {1'b0, START_KEY};
            keys_tried  <= {(KEY_W+1){1'b0}};
            core_busy_r <= {NUM_CORES{1'b0}};
            found_key   <= {KEY_W{1'b0}};
            found_core  <= 4'd0;
            busy        <= 1'b1;
            found       <= 1'b0;
            exhausted   <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          keys_tried <= keys_tried + done_cnt_s;
          if (hit_any_s) begin
            // A hit outranks exhaustion even on the final completion.
            state_r      <= ST_FOUND;
            found        <= 1'b1;
            busy         <= 1'b0;
            found_key    <= hit_key_s;
            found_core   <= hit_idx_s;
            core_abort_r <= 1'b1;
            core_busy_r  <= {NUM_CORES{1'b0}};
          end else if (!keys_left_s && all_free_s) begin
            state_r     <= ST_EXHAUSTED;
            exhausted   <= 1'b1;
            busy        <= 1'b0;
            core_busy_r <= {NUM_CORES{1'b0}};
          end else if (can_disp_s) begin
            core_busy_r  <= (core_busy_r & ~done_s) | disp_mask_s;
            core_start_r <= disp_mask_s;
            core_key_r[int'(disp_idx_s) * KEY_W +: KEY_W] <= next_key_r[KEY_W-1:0];
            display_key  <= next_key_r[KEY_W-1:0];
            next_key_r   <= next_key_r + (KEY_W+1)'(1'b1);
          end else begin
            core_busy_r <= core_busy_r & ~done_s;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          core_busy_r <= {NUM_CORES{1'b0}};
          busy        <= 1'b0;
          found       <= 1'b0;
          exhausted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rc4_key_dispatcher
//
// Directed bench. Instance A: 4 cores, 24-bit keys, range 0..0x3F, driven by
// behavioural cores with 10-cycle latency (or by hand-driven done/valid).
// Instance B: 2 cores, 4-bit keys, range 0xE..0xF, driven by hand.
// ---------------------------------------------------------------------------
module tb_rc4_key_dispatcher;

  logic        clk;
  logic        reset, start, pause;
  logic        busy, found, exhausted;
  logic [23:0] found_key, display_key;
  logic [3:0]  found_core;
  logic [24:0] keys_tried;

  logic        reset_b, start_b, pause_b;
  logic        busy_b, found_b, exhausted_b;
  logic [3:0]  found_key_b, display_key_b, found_core_b;
  logic [4:0]  keys_tried_b;

  rc4_key_dispatcher_if #(.NUM_CORES(4), .KEY_W(24)) ifa ();
  rc4_key_dispatcher_if #(.NUM_CORES(2), .KEY_W(4))  ifb ();

  rc4_key_dispatcher #(.NUM_CORES(4), .KEY_W(24), .START_KEY(24'h0), .MAX_KEY(24'h3F)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .cores(ifa),
    .busy(busy), .found(found), .exhausted(exhausted), .found_key(found_key),
    .found_core(found_core), .display_key(display_key), .keys_tried(keys_tried)
  );

  rc4_key_dispatcher #(.NUM_CORES(2), .KEY_W(4), .START_KEY(4'hE), .MAX_KEY(4'hF)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pause(pause_b), .cores(ifb),
    .busy(busy_b), .found(found_b), .exhausted(exhausted_b), .found_key(found_key_b),
    .found_core(found_core_b), .display_key(display_key_b), .keys_tried(keys_tried_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Behavioural core model state (written only by the core model process).
  logic [3:0]  bfm_done = 4'b0, bfm_valid = 4'b0, bfm_busy = 4'b0;
  int          bfm_cnt [4];
  logic [23:0] bfm_key [4];
  int          disp_cnt [64] = '{default: 0};
  int          max_disp = 0;
  int          abort_cnt = 0;
  int          done_total = 0;
  int          last_done_cyc = 0;
  int          start_after_found = 0;

  // Stimulus-owned controls.
  logic        bfm_on = 1'b0;
  logic [23:0] target = 24'hFFFFFF;
  logic [3:0]  man_done = 4'b0, man_valid = 4'b0;
  logic [1:0]  man_done_b = 2'b0, man_valid_b = 2'b0;

  assign ifa.core_done  = bfm_on ? bfm_done  : man_done;
  assign ifa.core_valid = bfm_on ? bfm_valid : man_valid;
  assign ifb.core_done  = man_done_b;
  assign ifb.core_valid = man_valid_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Core model and dispatch monitor for instance A, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      bfm_done  = 4'b0;
      bfm_valid = 4'b0;
      if (ifa.core_abort) begin
        abort_cnt++;
        bfm_busy = 4'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bfm_busy[i]) begin
            if (bfm_cnt[i] == 1) begin
              bfm_busy[i]  = 1'b0;
              bfm_done[i]  = 1'b1;
              bfm_valid[i] = (bfm_key[i] == target);
              done_total++;
              last_done_cyc = cyc;
            end else begin
              bfm_cnt[i]--;
            end
          end
        end
      end
      if (found && (ifa.core_start != 4'b0)) start_after_found++;
      for (int i = 0; i < 4; i++) begin
        if (ifa.core_start[i]) begin
          bfm_busy[i] = 1'b1;
          bfm_cnt[i]  = 10;
          bfm_key[i]  = ifa.core_key[i*24 +: 24];
          if (bfm_key[i] < 24'd64) disp_cnt[bfm_key[i]]++;
          if (int'(bfm_key[i]) > max_disp) max_disp = int'(bfm_key[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; pause_b = 1'b0;
    repeat (3) tick();
    reset = 1'b0; reset_b = 1'b0;
    tick();
    checks++; if ({busy, found, exhausted} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, found, exhausted}); end
    checks++; if (found_key !== 24'h0) begin errors++; $display("FAIL reset_found_key: got %h want 0", found_key); end
    checks++; if (found_core !== 4'h0) begin errors++; $display("FAIL reset_found_core: got %h want 0", found_core); end
    checks++; if (display_key !== 24'h0) begin errors++; $display("FAIL reset_display: got %h want 0", display_key); end
    checks++; if (keys_tried !== 25'h0) begin errors++; $display("FAIL reset_keys_tried: got %h want 0", keys_tried); end
    checks++; if ({ifa.core_start, ifa.core_abort} !== 5'b0) begin errors++; $display("FAIL reset_core_ctl: got %b want 0", {ifa.core_start, ifa.core_abort}); end
    checks++; if (ifa.core_key !== 96'h0) begin errors++; $display("FAIL reset_core_key: got %h want 0", ifa.core_key); end
    checks++; if ({busy_b, found_b, exhausted_b, keys_tried_b} !== 8'h0) begin errors++; $display("FAIL reset_b: got %h want 0", {busy_b, found_b, exhausted_b, keys_tried_b}); end
  endtask

  task automatic test_found();
    int base_abort;
    bit got;
    bfm_on = 1'b1; target = 24'h2A;
    base_abort = abort_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || ifa.core_start !== 4'b0) begin errors++; $display("FAIL start_run: busy=%b start=%b want 1/0000", busy, ifa.core_start); end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (ifa.core_start !== (4'b0001 << j) || display_key !== 24'(j) || ifa.core_key[j*24 +: 24] !== 24'(j)) begin
        errors++; $display("FAIL first_dispatch_%0d: start=%b disp=%h want %b/%h", j, ifa.core_start, display_key, 4'b0001 << j, j);
      end
    end
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      tick();
      if (found) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL found_timeout: found not seen in 1000 cycles"); end
    if (got) begin
      checks++; if (found_key !== 24'h2A) begin errors++; $display("FAIL found_key: got %h want 2a", found_key); end
      checks++; if (found_core !== 4'd2) begin errors++; $display("FAIL found_core: got %0d want 2", found_core); end
      checks++; if (ifa.core_abort !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL found_abort: abort=%b busy=%b want 1/0", ifa.core_abort, busy); end
      checks++; if (keys_tried !== 25'd43) begin errors++; $display("FAIL found_keys_tried: got %0d want 43", keys_tried); end
    end
    repeat (5) tick();
    checks++; if (found !== 1'b1 || found_key !== 24'h2A) begin errors++; $display("FAIL found_hold: found=%b key=%h want 1/2a", found, found_key); end
    checks++; if (abort_cnt - base_abort != 1) begin errors++; $display("FAIL abort_once: got %0d pulses want 1", abort_cnt - base_abort); end
    checks++; if (max_disp > 32'h2D) begin errors++; $display("FAIL max_dispatch: got %h want <= 2d", max_disp); end
    checks++; if (start_after_found != 0) begin errors++; $display("FAIL start_after_found: got %0d want 0", start_after_found); end
  endtask

  task automatic test_exhaust_pause();
    int disp_base [64];
    int done_base, pause_starts, bad;
    logic [23:0] prev_key;
    bit got;
    bfm_on = 1'b1; target = 24'hFFFFFF;
    for (int k = 0; k < 64; k++) disp_base[k] = disp_cnt[k];
    done_base = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (found !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart: found=%b busy=%b want 0/1", found, busy); end
    repeat (30) tick();
    pause = 1'b1;
    prev_key = display_key;
    pause_starts = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ifa.core_start !== 4'b0) pause_starts++;
    end
    checks++; if (pause_starts != 0) begin errors++; $display("FAIL pause_no_start: got %0d starts want 0", pause_starts); end
    checks++; if (display_key !== prev_key) begin errors++; $display("FAIL pause_display: got %h want %h", display_key, prev_key); end
    checks++; if (keys_tried !== 25'(done_total - done_base)) begin errors++; $display("FAIL pause_counted: got %0d want %0d", keys_tried, done_total - done_base); end
    pause = 1'b0;
    tick();
    checks++; if (ifa.core_start === 4'b0 || display_key !== prev_key + 24'd1) begin errors++; $display("FAIL pause_resume: start=%b disp=%h want nonzero/%h", ifa.core_start, display_key, prev_key + 24'd1); end
    got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      tick();
      if (exhausted) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL exhaust_timeout: exhausted not seen in 2000 cycles"); end
    if (got) begin
      checks++; if (cyc != last_done_cyc + 1) begin errors++; $display("FAIL exhaust_latency: got cycle %0d want %0d", cyc, last_done_cyc + 1); end
      checks++; if (keys_tried !== 25'd64) begin errors++; $display("FAIL exhaust_keys_tried: got %0d want 64", keys_tried); end
      checks++; if (found !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL exhaust_flags: found=%b busy=%b want 0/0", found, busy); end
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (disp_cnt[k] - disp_base[k] != 1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL exhaust_each_once: got %0d keys not dispatched exactly once want 0", bad); end
    checks++; if (max_disp > 32'h3F) begin errors++; $display("FAIL exhaust_range: max key %h want <= 3f", max_disp); end
  endtask

  task automatic test_simul_hit();
    bfm_on = 1'b0; man_done = 4'b0; man_valid = 4'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (ifa.core_key[47:24] !== 24'd1 || ifa.core_key[95:72] !== 24'd3) begin errors++; $display("FAIL simul_keys: c1=%h c3=%h want 1/3", ifa.core_key[47:24], ifa.core_key[95:72]); end
    man_done = 4'b1010; man_valid = 4'b1010;
    tick();
    man_done = 4'b0; man_valid = 4'b0;
    checks++; if (found !== 1'b1 || found_core !== 4'd1) begin errors++; $display("FAIL simul_core: found=%b core=%0d want 1/1", found, found_core); end
    checks++; if (found_key !== 24'd1) begin errors++; $display("FAIL simul_key: got %h want 1", found_key); end
    checks++; if (keys_tried !== 25'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", keys_tried); end
    checks++; if (ifa.core_abort !== 1'b1 || ifa.core_start !== 4'b0) begin errors++; $display("FAIL simul_abort: abort=%b start=%b want 1/0000", ifa.core_abort, ifa.core_start); end
    tick();
    checks++; if (ifa.core_abort !== 1'b0) begin errors++; $display("FAIL simul_abort_pulse: got %b want 0", ifa.core_abort); end
  endtask

  task automatic test_reset_midrun();
    bfm_on = 1'b0; man_done = 4'b0; man_valid = 4'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checks++; if ({busy, found, exhausted, found_core, keys_tried} !== 32'h0) begin errors++; $display("FAIL midrun_reset_flags: got %h want 0", {busy, found, exhausted, found_core, keys_tried}); end
    checks++; if (display_key !== 24'h0 || ifa.core_key !== 96'h0) begin errors++; $display("FAIL midrun_reset_keys: disp=%h keys=%h want 0", display_key, ifa.core_key); end
    checks++; if (ifa.core_abort !== 1'b0 || ifa.core_start !== 4'b0) begin errors++; $display("FAIL midrun_reset_ctl: abort=%b start=%b want 0/0000", ifa.core_abort, ifa.core_start); end
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ifa.core_start !== 4'b0) begin errors++; $display("FAIL post_reset_early: got %b want 0000", ifa.core_start); end
    tick();
    checks++; if (ifa.core_start !== 4'b0001 || ifa.core_key[23:0] !== 24'h0) begin errors++; $display("FAIL post_reset_dispatch: start=%b key=%h want 0001/0", ifa.core_start, ifa.core_key[23:0]); end
  endtask

  task automatic test_narrow_range();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    checks++; if (ifb.core_start !== 2'b01 || ifb.core_key[3:0] !== 4'hE) begin errors++; $display("FAIL narrow_first: start=%b key=%h want 01/e", ifb.core_start, ifb.core_key[3:0]); end
    tick();
    checks++; if (ifb.core_start !== 2'b10 || ifb.core_key[7:4] !== 4'hF) begin errors++; $display("FAIL narrow_second: start=%b key=%h want 10/f", ifb.core_start, ifb.core_key[7:4]); end
    tick();
    checks++; if (ifb.core_start !== 2'b00 || busy_b !== 1'b1 || display_key_b !== 4'hF) begin errors++; $display("FAIL narrow_no_wrap: start=%b busy=%b disp=%h want 00/1/f", ifb.core_start, busy_b, display_key_b); end
    man_done_b = 2'b11; man_valid_b = 2'b00;
    tick();
    man_done_b = 2'b00;
    checks++; if (exhausted_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL narrow_exhaust: exh=%b busy=%b want 1/0", exhausted_b, busy_b); end
    checks++; if (keys_tried_b !== 5'd2) begin errors++; $display("FAIL narrow_count: got %0d want 2", keys_tried_b); end
  endtask

  initial begin
    test_reset();
    test_found();
    test_exhaust_pause();
    test_simul_hit();
    test_reset_midrun();
    test_narrow_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
